scoreboard: RTL and testbench

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/scoreboard.sv | 159 +++++++++++++++
 tb/tb_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard.sv
// In-order scoreboard: a circular buffer of in-flight instructions that are filled
// at issue, completed by the writeback ports and retired oldest-first at commit.
package ariane_pkg;
  localparam int NR_SB_ENTRIES = 4;
  localparam int NR_WB_PORTS   = 2;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module scoreboard #(
  parameter int NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
  parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  output logic                                  full_o,
  input  ariane_pkg::scoreboard_entry_t         decoded_instr_i,
  input  logic                                  decoded_instr_valid_i,
  output logic                                  decoded_instr_ack_o,
  output ariane_pkg::scoreboard_entry_t         issue_instr_o,
  output logic                                  issue_instr_valid_o,
  input  logic                                  issue_ack_i,
  output ariane_pkg::scoreboard_entry_t         commit_instr_o,
  output logic                                  commit_valid_o,
  input  logic                                  commit_ack_i,
  input  logic [ariane_pkg::TRANS_ID_BITS-1:0]  trans_id_i [NR_WB_PORTS],
  input  logic [63:0]                           wdata_i    [NR_WB_PORTS],
  input  ariane_pkg::exception_t                ex_i       [NR_WB_PORTS],
  input  logic [NR_WB_PORTS-1:0]                wb_valid_i,
  output logic [31:0]                           rd_busy_o
);
  localparam int TB    = ariane_pkg::TRANS_ID_BITS;
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);

  ariane_pkg::scoreboard_entry_t mem_q [NR_ENTRIES];

  logic [TB-1:0]         issue_ptr_q, issue_ptr_d;
  logic [TB-1:0]         commit_ptr_q, commit_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NR_ENTRIES-1:0] occupied_q, occupied_d;
  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [NR_WB_PORTS-1:0] wb_ok;
  logic                  issue_fire, commit_fire;

  // NOTE: every output of a combinational block gets a default on entry, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    issue_instr_o          = decoded_instr_i;
    issue_instr_o.trans_id = issue_ptr_q;
    full_o                 = (count_q == CNT_W'(NR_ENTRIES));
    issue_instr_valid_o    = decoded_instr_valid_i & ~full_o & ~flush_i;
    decoded_instr_ack_o    = issue_ack_i & issue_instr_valid_o;
    commit_valid_o         = (count_q != '0);
    commit_instr_o         = mem_q[commit_ptr_q];
    commit_instr_o.valid   = valid_q[commit_ptr_q];
  end

  assign issue_fire  = decoded_instr_ack_o;
  assign commit_fire = commit_ack_i & commit_valid_o;

  // A writeback only lands on a slot that stays occupied into the next cycle.
  always_comb begin
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      wb_ok[p] = wb_valid_i[p] && occupied_q[trans_id_i[p]] && !flush_i &&
                 !(commit_fire && (trans_id_i[p] == commit_ptr_q));
    end
  end

  always_comb begin
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    occupied_d   = occupied_q;
    valid_d      = valid_q;
    count_d      = count_q;
    if (issue_fire) begin
      occupied_d[issue_ptr_q] = 1'b1;
      valid_d[issue_ptr_q]    = 1'b0;
      issue_ptr_d             = issue_ptr_q + 1'b1;
    end
    if (commit_fire) begin
      occupied_d[commit_ptr_q] = 1'b0;
      valid_d[commit_ptr_q]    = 1'b0;
      commit_ptr_d             = commit_ptr_q + 1'b1;
    end
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_ok[p]) valid_d[trans_id_i[p]] = 1'b1;
    end
    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      occupied_d   = '0;
      valid_d      = '0;
      count_d      = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      occupied_q   <= '0;
      valid_q      <= '0;
      count_q      <= '0;
    end else begin
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      occupied_q   <= occupied_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the payload array has no reset; it is only observed through slots whose
  // occupied/valid bits are reset, and leaving it unreset keeps it a plain RAM.
  // Later ports are written last, so the higher index wins a same-slot collision.
  always_ff @(posedge clk_i) begin
    if (issue_fire) mem_q[issue_ptr_q] <= issue_instr_o;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_ok[p]) begin
        mem_q[trans_id_i[p]].result <= wdata_i[p];
        if (ex_i[p].valid) mem_q[trans_id_i[p]].ex <= ex_i[p];
      end
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (occupied_q[i] && !valid_q[i]) rd_busy_o[mem_q[i].rd] = 1'b1;
    end
    rd_busy_o[0] = 1'b0;
  end
endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: a directed cycle table, hand-written
// writeback/reset sequences and a random run against an in-order queue model.
module tb_scoreboard;
  import ariane_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              full_o;
  scoreboard_entry_t dec;
  logic              dv;
  logic              ack;
  scoreboard_entry_t issue_instr;
  logic              issue_valid;
  logic              iack;
  scoreboard_entry_t commit_instr;
  logic              commit_valid;
  logic              cack;
  logic [1:0]        tid   [2];
  logic [63:0]       wdata [2];
  exception_t        ex    [2];
  logic [1:0]        wbv;
  logic [31:0]       rd_busy;

  int n_checks = 0;
  int n_err    = 0;

  scoreboard dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .flush_i              (flush_i),
    .full_o               (full_o),
    .decoded_instr_i      (dec),
    .decoded_instr_valid_i(dv),
    .decoded_instr_ack_o  (ack),
    .issue_instr_o        (issue_instr),
    .issue_instr_valid_o  (issue_valid),
    .issue_ack_i          (iack),
    .commit_instr_o       (commit_instr),
    .commit_valid_o       (commit_valid),
    .commit_ack_i         (cack),
    .trans_id_i           (tid),
    .wdata_i              (wdata),
    .ex_i                 (ex),
    .wb_valid_i           (wbv),
    .rd_busy_o            (rd_busy)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  // Reference model: the in-flight instructions in program order.
  scoreboard_entry_t mq[$];
  int                next_id = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic scoreboard_entry_t rand_entry();
    scoreboard_entry_t e;
    e.pc       = {$urandom, $urandom};
    e.trans_id = 2'($urandom);
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.rd       = 5'($urandom);
    e.result   = {$urandom, $urandom};
    e.valid    = 1'($urandom);
    e.ex.cause = 64'($urandom_range(0, 15));
    e.ex.tval  = {$urandom, $urandom};
    e.ex.valid = 1'($urandom);
    return e;
  endfunction

  task automatic idle();
    dv = 1'b0; iack = 1'b0; cack = 1'b0; flush_i = 1'b0; wbv = 2'b00;
    dec = rand_entry();
    for (int p = 0; p < 2; p++) begin
      tid[p] = 2'd0; wdata[p] = 64'd0; ex[p] = '0;
    end
  endtask

  task automatic check_model();
    scoreboard_entry_t e;
    logic [31:0]       busy;
    logic              can_issue;
    can_issue = dv && (mq.size() < 4) && !flush_i;
    chk1("full", full_o, mq.size() == 4);
    chk1("commit_valid", commit_valid, mq.size() != 0);
    if (mq.size() != 0) chkw("commit_instr", 320'(commit_instr), 320'(mq[0]));
    e = dec;
    e.trans_id = 2'(next_id);
    chkw("issue_instr", 320'(issue_instr), 320'(e));
    chk1("issue_valid", issue_valid, can_issue);
    chk1("decoded_ack", ack, can_issue && iack);
    busy = '0;
    foreach (mq[k]) if (!mq[k].valid) busy[mq[k].rd] = 1'b1;
    busy[0] = 1'b0;
    chkw("rd_busy", 320'(rd_busy), 320'(busy));
  endtask

  task automatic model_update();
    scoreboard_entry_t e;
    bit cfire, ifire;
    int start;
    if (flush_i) begin
      mq.delete();
      next_id = 0;
      return;
    end
    cfire = cack && (mq.size() != 0);
    ifire = dv && iack && (mq.size() < 4);
    start = cfire ? 1 : 0;
    for (int p = 0; p < 2; p++) begin
      if (wbv[p]) begin
        for (int k = start; k < mq.size(); k++) begin
          if (mq[k].trans_id == tid[p]) begin
            e = mq[k];
            e.result = wdata[p];
            e.valid  = 1'b1;
            if (ex[p].valid) e.ex = ex[p];
            mq[k] = e;
          end
        end
      end
    end
    if (cfire) void'(mq.pop_front());
    if (ifire) begin
      e = dec;
      e.trans_id = 2'(next_id);
      e.valid    = 1'b0;
      mq.push_back(e);
      next_id = (next_id + 1) % 4;
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 unit later.
  task automatic step();
    #1 check_model();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    #3 rst_ni = 1'b0;
    #1;
    chk1("rst_commit_valid", commit_valid, 1'b0);
    chk1("rst_full", full_o, 1'b0);
    chkw("rst_rd_busy", 320'(rd_busy), 320'(32'd0));
    mq.delete();
    next_id = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic       dv, iack, cack, flush;
    logic       e_ack, e_full, e_cv;
    logic [1:0] e_tid, e_ctid;
  } vec_t;

  vec_t tbl[13];

  initial begin
    //             dv    iack  cack  flush ack   full  cv    tid   ctid
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};

    idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk1("reset_commit_valid", commit_valid, 1'b0);
    chk1("reset_full", full_o, 1'b0);
    chkw("reset_rd_busy", 320'(rd_busy), 320'(32'd0));
    rst_ni = 1'b1;
    idle();
    step();

    // Fill to full, wrap, simultaneous issue/commit, flush with commit.
    foreach (tbl[i]) begin
      idle();
      dec.rd  = 5'd7;
      dv      = tbl[i].dv;
      iack    = tbl[i].iack;
      cack    = tbl[i].cack;
      flush_i = tbl[i].flush;
      #1;
      chk1($sformatf("tbl%0d_ack", i), ack, tbl[i].e_ack);
      chk1($sformatf("tbl%0d_full", i), full_o, tbl[i].e_full);
      chk1($sformatf("tbl%0d_cv", i), commit_valid, tbl[i].e_cv);
      chkw($sformatf("tbl%0d_tid", i), 320'(issue_instr.trans_id), 320'(tbl[i].e_tid));
      if (tbl[i].e_cv)
        chkw($sformatf("tbl%0d_ctid", i), 320'(commit_instr.trans_id), 320'(tbl[i].e_ctid));
      step();
    end

    // Asynchronous reset with an unfinished rd=7 entry in flight.
    idle();
    do_reset();
    idle();
    step();

    // rd busy then released by a writeback.
    idle(); dec.rd = 5'd5; dec.ex = '0; dv = 1'b1; iack = 1'b1;
    step();
    idle(); #1;
    chk1("busy_rd5_set", rd_busy[5], 1'b1);
    wbv[0] = 1'b1; tid[0] = 2'd0; wdata[0] = 64'hDEAD;
    step();
    idle(); #1;
    chk1("busy_rd5_clear", rd_busy[5], 1'b0);
    chkw("wb_result", 320'(commit_instr.result), 320'(64'hDEAD));
    chk1("wb_valid", commit_instr.valid, 1'b1);

    // Both ports hit id 1: port 1 wins.
    idle(); dec.rd = 5'd6; dv = 1'b1; iack = 1'b1;
    step();
    idle();
    wbv = 2'b11; tid[0] = 2'd1; tid[1] = 2'd1; wdata[0] = 64'h1; wdata[1] = 64'h2;
    cack = 1'b1;
    step();
    idle(); #1;
    chkw("dual_wb_id", 320'(commit_instr.trans_id), 320'(2'd1));
    chkw("dual_wb_result", 320'(commit_instr.result), 320'(64'h2));

    // Exception recorded through a writeback.
    idle(); dec.ex = '0; dv = 1'b1; iack = 1'b1;
    step();
    idle();
    wbv[1] = 1'b1; tid[1] = 2'd2; wdata[1] = 64'h55;
    ex[1].cause = ILLEGAL_INSTR; ex[1].tval = 64'h0; ex[1].valid = 1'b1;
    cack = 1'b1;
    step();
    idle(); #1;
    chkw("ex_id", 320'(commit_instr.trans_id), 320'(2'd2));
    chkw("ex_cause", 320'(commit_instr.ex.cause), 320'(64'd2));
    chk1("ex_valid", commit_instr.ex.valid, 1'b1);

    idle();
    do_reset();
    idle();
    step();

    for (int c = 0; c < 400; c++) begin
      idle();
      dv      = ($urandom_range(0, 3) != 0);
      iack    = ($urandom_range(0, 3) != 0);
      cack    = ($urandom_range(0, 1) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
      for (int p = 0; p < 2; p++) begin
        wbv[p]      = 1'($urandom_range(0, 1));
        tid[p]      = 2'($urandom);
        wdata[p]    = {$urandom, $urandom};
        ex[p].cause = 64'($urandom_range(0, 15));
        ex[p].tval  = {$urandom, $urandom};
        ex[p].valid = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
